// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline-stage register.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One valid+data+ctrl storage slot; load wins nothing over clear, clear drops valid and zeroes ctrl.
// Single-cycle update on posedge; no handshake of its own, the owner decides load/clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              vld_d,  vld_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  // Data is deliberately kept on clear so the output holds its last payload.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (clr) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (load) begin
      vld_d  = 1'b1;
      data_d = ld_data;
      ctrl_d = ld_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign vld  = vld_q;
  assign data = data_q;
  assign ctrl = ctrl_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with 2-entry skid, flush and zero-ctrl bubbles.
// Latency 1 cycle, full throughput; in_ready/out_valid registered, in_ready drops only when both entries are held.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  occ_state_e state_d, state_q;
  logic       in_ready_d, in_ready_q;

  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_vld & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (in_fire) state_d = OCC_ONE;
        OCC_ONE: begin
          if (in_fire && !out_fire)      state_d = OCC_FULL;
          else if (!in_fire && out_fire) state_d = OCC_EMPTY;
        end
        OCC_FULL:  if (out_fire) state_d = skid_vld ? OCC_ONE : OCC_EMPTY;
        default:   state_d = OCC_EMPTY;
      endcase
    end
    in_ready_d = (state_d != OCC_FULL);
  end

  // Flush overrides any handshake; a beat offered in the flush cycle is dropped.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: main_load = in_fire;
        OCC_ONE: begin
          if (in_fire && out_fire) main_load = 1'b1;
          else if (in_fire)        skid_load = 1'b1;
          else if (out_fire)       main_clr  = 1'b1;
        end
        OCC_FULL: begin
          if (out_fire) begin
            main_load      = skid_vld;
            main_clr       = !skid_vld;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clr     (main_clr),
    .ld_data (main_from_skid ? skid_data : in_data),
    .ld_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
    .vld     (main_vld),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clr     (skid_clr),
    .ld_data (in_data),
    .ld_ctrl (in_ctrl),
    .vld     (skid_vld),
    .data    (skid_data),
    .ctrl    (skid_ctrl)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the queue holds the beats the stage should be holding.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;

  int checks = 0;
  int fails  = 0;

  logic [39:0] sb[$];
  logic [31:0] m_last_dat = '0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  // {out_valid, in_ready, occupancy, out_ctrl, out_data} expected from the queue contents.
  function automatic logic [43:0] exp_state();
    logic [39:0] h;
    logic [1:0]  occ;
    h   = (sb.size() > 0) ? sb[0] : 40'd0;
    occ = 2'(sb.size());
    return {sb.size() > 0, sb.size() < 2, occ, h[39:32],
            (sb.size() > 0) ? h[31:0] : m_last_dat};
  endfunction

  function automatic logic [43:0] act_state();
    return {out_valid, in_ready, occupancy, out_ctrl, out_data};
  endfunction

  // Drive one cycle from a negedge; the model decides what fires, never the DUT.
  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl);
    logic m_in_fire, m_out_fire;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    m_in_fire  = iv && (sb.size() < 2);
    m_out_fire = ordy && (sb.size() > 0);
    if (m_out_fire) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (m_in_fire) sb.push_back({c, d});
    @(posedge clk);
    @(negedge clk);
    if (sb.size() > 0) m_last_dat = sb[0][31:0];
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_ctrl   = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (act_state() !== exp_state()) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, act_state(), exp_state());
      end
    end
    rst = 1'b1;
    drive(1'b1, 32'hCAFE0001, 8'h5A, 1'b0, 1'b0);
    checks++;
    if (act_state() !== exp_state()) begin
      fails++;
      $display("FAIL reset_prefill: got %h expected %h", act_state(), exp_state());
    end
    #2 rst = 1'b0;
    #1;
    sb.delete();
    m_last_dat = '0;
    checks++;
    if (act_state() !== exp_state()) begin
      fails++;
      $display("FAIL reset_async: got %h expected %h", act_state(), exp_state());
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (act_state() !== exp_state()) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", act_state(), exp_state());
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) drive(1'b1, 32'(i), 8'(i), 1'b1, 1'b0);
      else        drive(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (act_state() !== exp_state()) begin
        fails++;
        $display("FAIL stream[%0d]: got %h expected %h", i, act_state(), exp_state());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d_tab [7] = '{32'h11, 32'h22, 32'h33, 32'h33, 32'h33, 32'h0, 32'h0};
    logic        v_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        r_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(v_tab[i], d_tab[i], d_tab[i][7:0], r_tab[i], 1'b0);
      checks++;
      if (act_state() !== exp_state()) begin
        fails++;
        $display("FAIL backpressure[%0d]: got %h expected %h", i, act_state(), exp_state());
      end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hA1, 8'hFF, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (act_state() !== exp_state()) begin
      fails++;
      $display("FAIL flush_full: got %h expected %h", act_state(), exp_state());
    end
    drive(1'b1, 32'h99, 8'h77, 1'b0, 1'b1);
    checks++;
    if (act_state() !== exp_state()) begin
      fails++;
      $display("FAIL flush_cycle: got %h expected %h", act_state(), exp_state());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      checks++;
      if (act_state() !== exp_state()) begin
        fails++;
        $display("FAIL flush_after[%0d]: got %h expected %h", i, act_state(), exp_state());
      end
    end
  endtask

  task automatic test_push_pop();
    drive(1'b1, 32'h100, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i), (i % 2 == 1) ? 8'h80 : 8'h01, 1'b1, 1'b0);
      checks++;
      if (act_state() !== exp_state() || (out_valid && out_ctrl == 8'h00)) begin
        fails++;
        $display("FAIL push_pop[%0d]: got %h expected %h", i, act_state(), exp_state());
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 63) == 0);
      checks++;
      if (act_state() !== exp_state() || (!out_valid && out_ctrl !== 8'h00)) begin
        fails++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %h expected %h", i, act_state(), exp_state());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
